// File: rtl/main_store_banked.sv
// main_store_banked
//
// Banked bit-serial main store. Holds TUBES banks of 2**ADDR_BITS words of
// WORD_BITS bits. Every word time is a fixed beat sequence of
// P = WORD_BITS + FLYBACK_TIME + 2 beats:
//   beat 0                 FETCH     latch tube/addr/mode, read word, clear DATAIN
//   beats 1..WORD_BITS     DATA      shift word out / assemble DATAIN, LSB first
//   beat WORD_BITS+1       WRITEBACK store DATAIN (all modes except READ)
//   beats WORD_BITS+2..P-1 FLYBACK   idle, WORD_DONE in the last beat
//
// Ports:
//   w_CLK            clock, all state changes on the rising edge
//   w_RST_N          asynchronous active-low reset (memory contents kept)
//   b_MS_ADDR        word address, sampled in FETCH only
//   b_MS_TUBE        bank select, sampled in FETCH only
//   b_MS_MODE        00 READ, 01 WRITE, 10 MERGE, 11 CLEAR; sampled in FETCH
//   w_MS_DATA_IN     serial write data, LSB first, used in DATA beats
//   w_MS_ZERO        blanks w_MS_DATA_OUT for the current beat only
//   w_MS_DATA_OUT    serial read data, LSB first
//   w_MS_BEAT_START  high in the FETCH beat
//   w_MS_WORD_DONE   high in the last FLYBACK beat
//   b_MS_BEAT        current beat number 0..P-1 (doubles as the FSM state view)
//   b_MS_DATAMEM     word fetched this word time
//   b_MS_DATAIN      word being assembled for writeback

module main_store_banked #(
    parameter int WORD_BITS    = 20,
    parameter int ADDR_BITS    = 10,
    parameter int TUBES        = 2,
    parameter int FLYBACK_TIME = 4,
    localparam int TUBE_BITS   = (TUBES > 1) ? $clog2(TUBES) : 1,
    localparam int P           = WORD_BITS + FLYBACK_TIME + 2,
    localparam int BEAT_W      = $clog2(P)
) (
    input  logic                 w_CLK,
    input  logic                 w_RST_N,
    input  logic [ADDR_BITS-1:0] b_MS_ADDR,
    input  logic [TUBE_BITS-1:0] b_MS_TUBE,
    input  logic [1:0]           b_MS_MODE,
    input  logic                 w_MS_DATA_IN,
    input  logic                 w_MS_ZERO,
    output logic                 w_MS_DATA_OUT,
    output logic                 w_MS_BEAT_START,
    output logic                 w_MS_WORD_DONE,
    output logic [BEAT_W-1:0]    b_MS_BEAT,
    output logic [WORD_BITS-1:0] b_MS_DATAMEM,
    output logic [WORD_BITS-1:0] b_MS_DATAIN
);

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_MERGE = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // Phase decoded from the beat counter; the counter itself is the state.
    localparam logic [1:0] PH_FETCH   = 2'd0;
    localparam logic [1:0] PH_DATA    = 2'd1;
    localparam logic [1:0] PH_WB      = 2'd2;
    localparam logic [1:0] PH_FLYBACK = 2'd3;

    localparam logic [BEAT_W-1:0] BEAT_LAST_DATA = BEAT_W'(WORD_BITS);
    localparam logic [BEAT_W-1:0] BEAT_WB        = BEAT_W'(WORD_BITS + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST      = BEAT_W'(P - 1);

    // Banks are laid out back to back: flat index = {tube, addr}.
    localparam int MEM_WORDS = TUBES << ADDR_BITS;
    localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [WORD_BITS-1:0] mem [MEM_WORDS];

    logic [BEAT_W-1:0]    beat;
    logic [TUBE_BITS-1:0] tube_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [1:0]           mode_q;
    logic [WORD_BITS-1:0] datamem;
    logic [WORD_BITS-1:0] datain;

    logic [1:0]           phase;
    logic [BEAT_W-1:0]    bit_idx;
    logic [WORD_BITS-1:0] mem_shift;
    logic [WORD_BITS-1:0] bit_mask;
    logic                 new_bit;
    logic                 fetch_tube_ok;
    logic                 wb_tube_ok;
    logic [MEM_AW-1:0]    fetch_idx;
    logic [MEM_AW-1:0]    wb_idx;

    always_comb begin
        phase = PH_FLYBACK;
        if (beat == '0) begin
            phase = PH_FETCH;
        end else if (beat <= BEAT_LAST_DATA) begin
            phase = PH_DATA;
        end else if (beat == BEAT_WB) begin
            phase = PH_WB;
        end
    end

    // Bit position for the DATA beats; shift/mask keep index widths exact.
    assign bit_idx   = beat - BEAT_W'(1);
    assign mem_shift = datamem >> bit_idx;
    assign bit_mask  = WORD_BITS'(1) << bit_idx;

    always_comb begin
        new_bit = 1'b0;
        case (mode_q)
            MODE_READ:  new_bit = mem_shift[0];
            MODE_WRITE: new_bit = w_MS_DATA_IN;
            MODE_MERGE: new_bit = mem_shift[0] | w_MS_DATA_IN;
            MODE_CLEAR: new_bit = 1'b0;
            default:    new_bit = 1'b0;
        endcase
    end

    // Out-of-range banks read as zero and swallow writes.
    assign fetch_tube_ok = (int'(b_MS_TUBE) < TUBES);
    assign wb_tube_ok    = (int'(tube_q) < TUBES);
    assign fetch_idx     = MEM_AW'({b_MS_TUBE, b_MS_ADDR});
    assign wb_idx        = MEM_AW'({tube_q, addr_q});

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            beat    <= '0;
            tube_q  <= '0;
            addr_q  <= '0;
            mode_q  <= MODE_READ;
            datamem <= '0;
            datain  <= '0;
        end else begin
            beat <= (beat == BEAT_LAST) ? '0 : beat + BEAT_W'(1);
            case (phase)
                PH_FETCH: begin
                    tube_q  <= b_MS_TUBE;
                    addr_q  <= b_MS_ADDR;
                    mode_q  <= b_MS_MODE;
                    datamem <= fetch_tube_ok ? mem[fetch_idx] : '0;
                    datain  <= '0;
                end
                PH_DATA: begin
                    if (new_bit) begin
                        datain <= datain | bit_mask;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage is never reset. Reset forces the beat counter to FETCH, so an
    // aborted word can never reach its writeback beat.
    always_ff @(posedge w_CLK) begin
        if (phase == PH_WB && mode_q != MODE_READ && wb_tube_ok) begin
            mem[wb_idx] <= datain;
        end
    end

    // Output is a gate of registered values; w_MS_ZERO blanks it for this beat.
    assign w_MS_DATA_OUT   = (phase == PH_DATA) && !w_MS_ZERO &&
                             (mode_q != MODE_CLEAR) && mem_shift[0];
    assign w_MS_BEAT_START = (beat == '0);
    assign w_MS_WORD_DONE  = (beat == BEAT_LAST);
    assign b_MS_BEAT       = beat;
    assign b_MS_DATAMEM    = datamem;
    assign b_MS_DATAIN     = datain;

endmodule

// File: tb/tb_main_store_banked.sv
// Directed bench for main_store_banked: WORD_BITS=8, ADDR_BITS=3, TUBES=2,
// FLYBACK_TIME=2, so a word time is 12 beats. Inputs change on the falling
// edge; outputs are sampled 1 ns later, away from the rising edge.

module tb_main_store_banked;

    localparam int WB = 8;
    localparam int AB = 3;
    localparam int NT = 2;
    localparam int FT = 2;
    localparam int P  = WB + FT + 2;

    localparam logic [1:0] M_READ  = 2'b00;
    localparam logic [1:0] M_WRITE = 2'b01;
    localparam logic [1:0] M_MERGE = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic          w_CLK = 1'b0;
    logic          w_RST_N = 1'b0;
    logic [AB-1:0] b_MS_ADDR = '0;
    logic          b_MS_TUBE = 1'b0;
    logic [1:0]    b_MS_MODE = 2'b00;
    logic          w_MS_DATA_IN = 1'b0;
    logic          w_MS_ZERO = 1'b0;
    logic          w_MS_DATA_OUT;
    logic          w_MS_BEAT_START;
    logic          w_MS_WORD_DONE;
    logic [3:0]    b_MS_BEAT;
    logic [WB-1:0] b_MS_DATAMEM;
    logic [WB-1:0] b_MS_DATAIN;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected serial-out bit for each beat of the word in flight.
    logic exp_q[$];

    main_store_banked #(
        .WORD_BITS   (WB),
        .ADDR_BITS   (AB),
        .TUBES       (NT),
        .FLYBACK_TIME(FT)
    ) dut (
        .w_CLK          (w_CLK),
        .w_RST_N        (w_RST_N),
        .b_MS_ADDR      (b_MS_ADDR),
        .b_MS_TUBE      (b_MS_TUBE),
        .b_MS_MODE      (b_MS_MODE),
        .w_MS_DATA_IN   (w_MS_DATA_IN),
        .w_MS_ZERO      (w_MS_ZERO),
        .w_MS_DATA_OUT  (w_MS_DATA_OUT),
        .w_MS_BEAT_START(w_MS_BEAT_START),
        .w_MS_WORD_DONE (w_MS_WORD_DONE),
        .b_MS_BEAT      (b_MS_BEAT),
        .b_MS_DATAMEM   (b_MS_DATAMEM),
        .b_MS_DATAIN    (b_MS_DATAIN)
    );

    // ---------------- clock / watchdog ----------------
    always #5 w_CLK = ~w_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one full word starting at a falling edge in beat 0 and returns at
    // the falling edge of the next beat 0. mem_known=0 skips checks that
    // depend on never-written storage. scramble moves the command inputs at
    // beat 3; the word must carry on with the values latched in FETCH.
    task automatic run_word(input string tag, input logic tube, input logic [AB-1:0] addr,
                            input logic [1:0] mode, input logic [WB-1:0] din,
                            input logic zero, input logic mem_known,
                            input logic [WB-1:0] exp_mem, input logic [WB-1:0] exp_in,
                            input logic scramble);
        logic exp_bit;
        for (int b = 0; b < P; b++) begin
            exp_q.push_back((b >= 1 && b <= WB && !zero && mode != M_CLEAR) ? exp_mem[b-1] : 1'b0);
        end
        for (int b = 0; b < P; b++) begin
            if (b == 0) begin
                b_MS_TUBE = tube;
                b_MS_ADDR = addr;
                b_MS_MODE = mode;
            end else if (scramble && b == 3) begin
                b_MS_TUBE = ~tube;
                b_MS_ADDR = addr ^ 3'b110;
                b_MS_MODE = M_WRITE;
            end
            w_MS_DATA_IN = (b >= 1 && b <= WB) ? din[b-1] : 1'b1;
            w_MS_ZERO    = zero;
            #1;
            exp_bit = exp_q.pop_front();
            check_eq({tag, ".beat"}, 32'(b_MS_BEAT), 32'(b));
            check_eq({tag, ".beat_start"}, 32'(w_MS_BEAT_START), 32'(b == 0));
            check_eq({tag, ".word_done"}, 32'(w_MS_WORD_DONE), 32'(b == P - 1));
            if (mem_known || zero || b == 0 || b > WB) begin
                check_eq({tag, ".data_out"}, 32'(w_MS_DATA_OUT), 32'(exp_bit));
            end
            if (b == 1 && mem_known) begin
                check_eq({tag, ".datamem"}, 32'(b_MS_DATAMEM), 32'(exp_mem));
            end
            if (b == WB + 2) begin
                check_eq({tag, ".datain"}, 32'(b_MS_DATAIN), 32'(exp_in));
            end
            @(negedge w_CLK);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge w_CLK);
        #1;
        check_eq("rst.beat", 32'(b_MS_BEAT), 32'd0);
        check_eq("rst.beat_start", 32'(w_MS_BEAT_START), 32'd1);
        check_eq("rst.word_done", 32'(w_MS_WORD_DONE), 32'd0);
        check_eq("rst.data_out", 32'(w_MS_DATA_OUT), 32'd0);
        check_eq("rst.datamem", 32'(b_MS_DATAMEM), 32'd0);
        check_eq("rst.datain", 32'(b_MS_DATAIN), 32'd0);
        @(negedge w_CLK);
        w_RST_N = 1'b1;

        // 1: write / read back
        run_word("s1_wr",  1'b1, 3'd3, M_WRITE, 8'hA5, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);
        run_word("s1_rd",  1'b1, 3'd3, M_READ,  8'hFF, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0);
        // 2: merge
        run_word("s2_mg",  1'b1, 3'd3, M_MERGE, 8'h0F, 1'b0, 1'b1, 8'hA5, 8'hAF, 1'b0);
        run_word("s2_rd",  1'b1, 3'd3, M_READ,  8'hFF, 1'b0, 1'b1, 8'hAF, 8'hAF, 1'b0);
        // 3: banks are independent
        run_word("s3_wr0", 1'b0, 3'd3, M_WRITE, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0);
        run_word("s3_rd1", 1'b1, 3'd3, M_READ,  8'hFF, 1'b0, 1'b1, 8'hAF, 8'hAF, 1'b0);
        run_word("s3_rd0", 1'b0, 3'd3, M_READ,  8'h00, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0);
        // 4: zero blanking, then clear
        run_word("s4_zr",  1'b1, 3'd3, M_READ,  8'hFF, 1'b1, 1'b1, 8'hAF, 8'hAF, 1'b0);
        run_word("s4_rd",  1'b1, 3'd3, M_READ,  8'hFF, 1'b0, 1'b1, 8'hAF, 8'hAF, 1'b0);
        run_word("s4_clr", 1'b1, 3'd3, M_CLEAR, 8'hFF, 1'b0, 1'b1, 8'hAF, 8'h00, 1'b0);
        run_word("s4_rd2", 1'b1, 3'd3, M_READ,  8'hFF, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);

        // 5: reset during a write aborts it
        run_word("s5_wr",  1'b0, 3'd5, M_WRITE, 8'h11, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0);
        for (int b = 0; b < 4; b++) begin
            b_MS_TUBE    = 1'b0;
            b_MS_ADDR    = 3'd5;
            b_MS_MODE    = M_WRITE;
            w_MS_DATA_IN = 1'b1;
            w_MS_ZERO    = 1'b0;
            @(negedge w_CLK);
        end
        #1;
        check_eq("s5_abort.pre_beat", 32'(b_MS_BEAT), 32'd4);
        w_RST_N = 1'b0;
        #1;
        check_eq("s5_abort.beat", 32'(b_MS_BEAT), 32'd0);
        check_eq("s5_abort.data_out", 32'(w_MS_DATA_OUT), 32'd0);
        check_eq("s5_abort.word_done", 32'(w_MS_WORD_DONE), 32'd0);
        check_eq("s5_abort.beat_start", 32'(w_MS_BEAT_START), 32'd1);
        check_eq("s5_abort.datamem", 32'(b_MS_DATAMEM), 32'd0);
        check_eq("s5_abort.datain", 32'(b_MS_DATAIN), 32'd0);
        repeat (2) @(negedge w_CLK);
        w_RST_N = 1'b1;
        run_word("s5_rd",  1'b0, 3'd5, M_READ,  8'hFF, 1'b0, 1'b1, 8'h11, 8'h11, 1'b0);

        // 6: command inputs moved mid-word are ignored
        run_word("s6_wr",  1'b1, 3'd3, M_WRITE, 8'h5A, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b0);
        run_word("s6_scr", 1'b1, 3'd3, M_READ,  8'hFF, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b1);
        run_word("s6_rd0", 1'b0, 3'd5, M_READ,  8'hFF, 1'b0, 1'b1, 8'h11, 8'h11, 1'b0);
        run_word("s6_rd1", 1'b1, 3'd3, M_READ,  8'h00, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_store_banked.md
Name: main_store_banked

Overview:
Parametrised serial main store, successor to the single-tube store. It holds TUBES independent banks of 2**ADDR_BITS words, each WORD_BITS wide. Each word time runs a fixed beat sequence: fetch, serial data, writeback, flyback. Words are read and written bit-serially, LSB first. Per-word modes are READ, WRITE (replace), MERGE (OR into stored word) and CLEAR. The block sits between the control unit/accumulator serial buses and the store tubes.

Parameters:
WORD_BITS, 20, bits per word.
ADDR_BITS, 10, address bits per tube.
TUBES, 2, number of banks; must be >=1.
FLYBACK_TIME, 4, idle beats at end of word; must be >=1.
TUBE_BITS (localparam), max(1, clog2(TUBES)), tube-select width.

Ports:
w_CLK  in  1  clock; all state changes on rising edge.
w_RST_N  in  1  asynchronous, active-low reset.
b_MS_ADDR  in  ADDR_BITS  word address; sampled in FETCH only.
b_MS_TUBE  in  TUBE_BITS  tube select; sampled in FETCH only.
b_MS_MODE  in  2  00 READ, 01 WRITE, 10 MERGE, 11 CLEAR; sampled in FETCH only.
w_MS_DATA_IN  in  1  serial write data, LSB first, sampled during DATA beats.
w_MS_ZERO  in  1  forces w_MS_DATA_OUT to 0 in the current beat; no effect on storage.
w_MS_DATA_OUT  out  1  serial read data, LSB first.
w_MS_BEAT_START  out  1  high during the FETCH beat.
w_MS_WORD_DONE  out  1  high during the last FLYBACK beat.
b_MS_BEAT  out  clog2(P)  current beat number, 0..P-1.
b_MS_DATAMEM  out  WORD_BITS  word fetched this word time.
b_MS_DATAIN  out  WORD_BITS  word being assembled for writeback.

Behaviour:
- Word period: P = WORD_BITS + FLYBACK_TIME + 2 beats. The beat counter wraps from P-1 to 0.
- FETCH, beat 0:
  - Latch tube, addr and mode.
  - Synchronous read of mem[tube][addr] into the DATAMEM register, valid from beat 1.
  - Clear the DATAIN register.
  - w_MS_BEAT_START=1; w_MS_DATA_OUT=0.
- DATA, beats 1..WORD_BITS, bit index i = beat-1:
  - w_MS_DATA_OUT = DATAMEM[i]. It is forced to 0 if w_MS_ZERO=1 or the latched mode is CLEAR.
  - The output is a mux of registered values only.
  - At the edge ending the beat, DATAIN[i] is set as follows:
    - READ: DATAMEM[i]
    - WRITE: w_MS_DATA_IN
    - MERGE: DATAMEM[i] | w_MS_DATA_IN
    - CLEAR: 0
- WRITEBACK, beat WORD_BITS+1:
  - Modes other than READ write DATAIN to mem[tube][addr] at the edge ending this beat.
  - READ performs no write.
  - w_MS_DATA_OUT=0.
- FLYBACK, beats WORD_BITS+2..P-1:
  - w_MS_DATA_OUT=0.
  - w_MS_WORD_DONE=1 in beat P-1 only.
- Input changes outside FETCH are ignored for the whole word; command inputs are not re-sampled mid-word.
- Write-then-read of the same address in consecutive words: the next FETCH returns the new value, since writeback precedes the next fetch.
- Out-of-range tube (index >= TUBES): reads return 0, writes are discarded.
- Reset (w_RST_N=0), taking effect immediately:
  - Beat counter 0; all registers and outputs 0, except w_MS_BEAT_START, which is 1 because the block is in FETCH.
  - Memory contents are not cleared.
  - Reset mid-word aborts the word with no writeback.
  - After release, the first edge executes FETCH.

Test Plan:
Configuration for all scenarios: WORD_BITS=8, ADDR_BITS=3, TUBES=2, FLYBACK_TIME=2, so P=12.
1. WRITE tube1 addr3, DIN stream 1,0,1,0,0,1,0,1 (0xA5), then READ tube1 addr3 -> DATA_OUT 1,0,1,0,0,1,0,1 on beats 1..8; DATAMEM=0xA5.
2. MERGE 0x0F into tube1 addr3 -> during the merge word DATA_OUT shows 0xA5 and DATAIN ends 0xAF; next READ gives 0xAF.
3. WRITE tube0 addr3=0x3C -> READ tube1 addr3 still 0xAF; READ tube0 addr3 gives 0x3C.
4. READ tube1 addr3 with w_MS_ZERO=1 throughout -> DATA_OUT all 0; the following READ gives 0xAF. Then CLEAR -> next READ gives 0x00.
5. Write addr5=0x11; start WRITE 0xFF to addr5 and pull w_RST_N low at beat 4 -> DATA_OUT and WORD_DONE drop to 0 immediately; after release, READ addr5 gives 0x11.
6. Change ADDR and MODE at beat 3 of a READ of addr3 -> DATAMEM unchanged, no write occurs; BEAT_START high every 12 cycles at beat 0; WORD_DONE high at beat 11 only.
